// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter: state encoding,
// round-robin pick function and the default read-ID FIFO depth.
package mem_arb_pkg;

   typedef enum logic {
      S_ARB   = 1'b0,
      S_ISSUE = 1'b1
   } arb_state_t;

   localparam int DEFAULT_MAX_OUTSTANDING = 4;
   localparam int MAX_REQ = 8;

   // First set bit of req scanning ptr, ptr+1, ... modulo num_req; 0 if none.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                  input int ptr,
                                  input int num_req);
      int   pick;
      int   idx;
      logic found;
      pick  = 0;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         idx = (ptr + i) % num_req;
         if ((i < num_req) && !found && req[idx[2:0]]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester IDs for reads in flight; head is the owner
// of the next returning read word.
module mem_arb_id_fifo
   import mem_arb_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
   input  logic                     clk_sys,
   input  logic                     rst_b,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_id,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_id,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head_id = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_id;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_REQ requesters and routes read data back
// in issue order. Define MEM_ARB_FIXED_PRIORITY_EN for lowest-index-wins.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_ARB   | bubble cycle: pick a requester if any is valid and FIFO not full
//  S_ISSUE | forward the granted requester to memory until accepted
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int ID_WIDTH        = 1,
   parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
   input  logic                               CLK,
   input  logic                               RST_N,
   input  logic [NUM_REQ-1:0]                 REQ_SEND_ADDR_VALID,
   input  logic [32*NUM_REQ-1:0]              REQ_SEND_ADDR,
   input  logic [NUM_REQ-1:0]                 REQ_SEND_DATA_VALID,
   input  logic [32*NUM_REQ-1:0]              REQ_SEND_DATA,
   output logic [NUM_REQ-1:0]                 REQ_SEND_READY,
   output logic [NUM_REQ-1:0]                 REQ_RECEIVE_VALID,
   output logic [31:0]                        REQ_RECEIVE_DATA,
   input  logic [NUM_REQ-1:0]                 REQ_RECEIVE_READY,
   output logic                               MEM_SEND_ADDR_VALID,
   output logic [31:0]                        MEM_SEND_ADDR,
   output logic                               MEM_SEND_DATA_VALID,
   output logic [31:0]                        MEM_SEND_DATA,
   input  logic                               MEM_SEND_READY,
   input  logic                               MEM_RECEIVE_VALID,
   input  logic [31:0]                        MEM_RECEIVE_DATA,
   output logic                               MEM_RECEIVE_READY,
   output logic [$clog2(MAX_OUTSTANDING):0]   OUTSTANDING,
   output logic                               ERR_UNEXPECTED
);

   arb_state_t          state;
   arb_state_t          state_next;
   logic [ID_WIDTH-1:0] grant;
   logic [ID_WIDTH-1:0] pick;
   logic [ID_WIDTH-1:0] head;
   logic [MAX_REQ-1:0]  req_pad;
   logic                arb_go;
   logic                fifo_full;
   logic                fifo_empty;
   logic                send_fire;
   logic                push;
   logic                pop;
   logic                head_ready;
   logic                sel_av;
   logic                sel_dv;
   logic [31:0]         sel_addr;
   logic [31:0]         sel_data;

`ifndef MEM_ARB_FIXED_PRIORITY_EN
   logic [ID_WIDTH-1:0] rr_ptr;
`endif

   always_comb begin
      req_pad = '0;
      req_pad[NUM_REQ-1:0] = REQ_SEND_ADDR_VALID;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      pick = ID_WIDTH'(rr_pick(req_pad, 0, NUM_REQ));
`else
      pick = ID_WIDTH'(rr_pick(req_pad, int'(rr_ptr), NUM_REQ));
`endif
   end

   assign arb_go = (|REQ_SEND_ADDR_VALID) && !fifo_full;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= S_ARB;
         grant <= '0;
      end else begin
         state <= state_next;
         if ((state == S_ARB) && arb_go) grant <= pick;
      end
   end

`ifndef MEM_ARB_FIXED_PRIORITY_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rr_ptr <= '0;
      end else if (send_fire) begin
         rr_ptr <= (grant == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant + ID_WIDTH'(1);
      end
   end
`endif

   always_comb begin
      state_next = state;
      case (state)
         S_ARB:   if (arb_go) state_next = S_ISSUE;
         S_ISSUE: if (send_fire) state_next = S_ARB;
         default: state_next = S_ARB;
      endcase
   end

   always_comb begin
      sel_av         = 1'b0;
      sel_dv         = 1'b0;
      sel_addr       = '0;
      sel_data       = '0;
      REQ_SEND_READY = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_WIDTH'(i)) begin
            sel_av   = REQ_SEND_ADDR_VALID[i];
            sel_dv   = REQ_SEND_DATA_VALID[i];
            sel_addr = REQ_SEND_ADDR[32*i +: 32];
            sel_data = REQ_SEND_DATA[32*i +: 32];
            if (state == S_ISSUE) REQ_SEND_READY[i] = MEM_SEND_READY;
         end
      end
      MEM_SEND_ADDR       = sel_addr;
      MEM_SEND_DATA       = sel_data;
      MEM_SEND_ADDR_VALID = (state == S_ISSUE) && sel_av;
      MEM_SEND_DATA_VALID = (state == S_ISSUE) && sel_dv;
   end

   assign send_fire = MEM_SEND_ADDR_VALID && MEM_SEND_READY;
   assign push      = send_fire && !MEM_SEND_DATA_VALID;

   always_comb begin
      head_ready        = 1'b0;
      REQ_RECEIVE_VALID = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (head == ID_WIDTH'(i)) begin
            head_ready           = REQ_RECEIVE_READY[i];
            REQ_RECEIVE_VALID[i] = MEM_RECEIVE_VALID && !fifo_empty;
         end
      end
      MEM_RECEIVE_READY = !fifo_empty && head_ready;
      REQ_RECEIVE_DATA  = MEM_RECEIVE_DATA;
   end

   assign pop = MEM_RECEIVE_VALID && MEM_RECEIVE_READY;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ERR_UNEXPECTED <= 1'b0;
      end else if (MEM_RECEIVE_VALID && fifo_empty) begin
         ERR_UNEXPECTED <= 1'b1;
      end
   end

   mem_arb_id_fifo #(
      .WIDTH (ID_WIDTH),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_sys (CLK),
      .rst_b   (RST_N),
      .push    (push),
      .push_id (grant),
      .pop     (pop),
      .head_id (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (OUTSTANDING)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with two requesters and a 4-deep ID FIFO.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  av;
   logic [63:0] addr;
   logic [1:0]  dv;
   logic [63:0] wdata;
   logic [1:0]  send_ready;
   logic [1:0]  rx_valid;
   logic [31:0] rx_data;
   logic [1:0]  rx_ready;
   logic        m_av;
   logic [31:0] m_addr;
   logic        m_dv;
   logic [31:0] m_data;
   logic        m_ready;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic        m_rready;
   logic [2:0]  outstanding;
   logic        err;

   int         total = 0;
   int         bad   = 0;
   logic [0:0] exp_q[$];
   logic [0:0] g;
   logic [0:0] id;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .CLK                 (clk),
      .RST_N               (rst_n),
      .REQ_SEND_ADDR_VALID (av),
      .REQ_SEND_ADDR       (addr),
      .REQ_SEND_DATA_VALID (dv),
      .REQ_SEND_DATA       (wdata),
      .REQ_SEND_READY      (send_ready),
      .REQ_RECEIVE_VALID   (rx_valid),
      .REQ_RECEIVE_DATA    (rx_data),
      .REQ_RECEIVE_READY   (rx_ready),
      .MEM_SEND_ADDR_VALID (m_av),
      .MEM_SEND_ADDR       (m_addr),
      .MEM_SEND_DATA_VALID (m_dv),
      .MEM_SEND_DATA       (m_data),
      .MEM_SEND_READY      (m_ready),
      .MEM_RECEIVE_VALID   (m_rvalid),
      .MEM_RECEIVE_DATA    (m_rdata),
      .MEM_RECEIVE_READY   (m_rready),
      .OUTSTANDING         (outstanding),
      .ERR_UNEXPECTED      (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] onehot(input logic [0:0] i);
      logic [31:0] v;
      v = 32'd1 << i;
      return v;
   endfunction

   initial begin
      rst_n    = 1'b0;
      av       = '0;
      addr     = '0;
      dv       = '0;
      wdata    = '0;
      rx_ready = '0;
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      #3;
      chk("rst_send_ready", 32'(send_ready), 32'h0);
      chk("rst_mem_av", 32'(m_av), 32'h0);
      chk("rst_mem_dv", 32'(m_dv), 32'h0);
      chk("rst_outstanding", 32'(outstanding), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_rx_valid", 32'(rx_valid), 32'h0);
      chk("rst_mem_rready", 32'(m_rready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // single read from requester 0
      cyc();
      m_ready     = 1'b1;
      rx_ready    = 2'b11;
      av          = 2'b01;
      addr[31:0]  = 32'h100;
      #1 chk("rd_bubble", 32'(m_av), 32'h0);
      cyc();
      #1;
      chk("rd_mem_av", 32'(m_av), 32'h1);
      chk("rd_mem_addr", m_addr, 32'h100);
      chk("rd_mem_dv", 32'(m_dv), 32'h0);
      chk("rd_send_ready", 32'(send_ready), 32'h1);
      exp_q.push_back(1'b0);
      cyc();
      av = 2'b00;
      #1;
      chk("rd_outstanding1", 32'(outstanding), 32'h1);
      chk("rd_mem_av_after", 32'(m_av), 32'h0);
      cyc();
      cyc();
      m_rvalid = 1'b1;
      m_rdata  = 32'hDEADBEEF;
      #1;
      id = exp_q.pop_front();
      chk("rd_rx_valid", 32'(rx_valid), onehot(id));
      chk("rd_rx_data", rx_data, 32'hDEADBEEF);
      chk("rd_mem_rready", 32'(m_rready), 32'h1);
      cyc();
      m_rvalid = 1'b0;
      #1 chk("rd_outstanding0", 32'(outstanding), 32'h0);

      // write from requester 1
      av           = 2'b10;
      dv           = 2'b10;
      addr[63:32]  = 32'h200;
      wdata[63:32] = 32'h55;
      #1 chk("wr_bubble", 32'(m_av), 32'h0);
      cyc();
      #1;
      chk("wr_mem_av", 32'(m_av), 32'h1);
      chk("wr_mem_dv", 32'(m_dv), 32'h1);
      chk("wr_mem_addr", m_addr, 32'h200);
      chk("wr_mem_data", m_data, 32'h55);
      chk("wr_send_ready", 32'(send_ready), 32'h2);
      cyc();
      av = 2'b00;
      dv = 2'b00;
      #1 chk("wr_outstanding", 32'(outstanding), 32'h0);

      // contention: both requesters read continuously
      addr = {32'h2000, 32'h1000};
      av   = 2'b11;
      for (int k = 0; k < 4; k++) begin
         cyc();
         #1;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
         g = 1'b0;
`else
         g = 1'(k % 2);
`endif
         chk("cont_send_ready", 32'(send_ready), onehot(g));
         chk("cont_mem_addr", m_addr, g ? 32'h2000 : 32'h1000);
         exp_q.push_back(g);
         cyc();
      end
      av = 2'b00;
      #1 chk("cont_outstanding", 32'(outstanding), 32'h4);

      // backpressure: FIFO full with memory silent
      addr[31:0] = 32'h3000;
      av         = 2'b01;
      cyc();
      cyc();
      #1 chk("full_no_issue", 32'(m_av), 32'h0);
      rx_ready = 2'b00;
      m_rvalid = 1'b1;
      m_rdata  = 32'hA0A0A0A0;
      #1;
      chk("bp_mem_rready", 32'(m_rready), 32'h0);
      chk("bp_rx_valid", 32'(rx_valid), onehot(exp_q[0]));
      cyc();
      #1;
      chk("bp_outstanding", 32'(outstanding), 32'h4);
      chk("bp_no_issue", 32'(m_av), 32'h0);
      rx_ready = 2'b11;
      #1 chk("bp_mem_rready_on", 32'(m_rready), 32'h1);
      id = exp_q.pop_front();
      cyc();
      m_rvalid = 1'b0;
      #1;
      chk("free_outstanding", 32'(outstanding), 32'h3);
      chk("free_bubble", 32'(m_av), 32'h0);
      cyc();
      #1;
      chk("free_issue_av", 32'(m_av), 32'h1);
      chk("free_issue_addr", m_addr, 32'h3000);
      exp_q.push_back(1'b0);
      cyc();
      #1 chk("refull_outstanding", 32'(outstanding), 32'h4);
      cyc();
      cyc();
      #1 chk("refull_no_issue", 32'(m_av), 32'h0);
      av = 2'b00;

      // drain the four reads in issue order
      for (int k = 0; k < 4; k++) begin
         m_rvalid = 1'b1;
         m_rdata  = 32'hB0000000 + 32'(k);
         #1;
         id = exp_q.pop_front();
         chk("drain_rx_valid", 32'(rx_valid), onehot(id));
         chk("drain_rx_data", rx_data, 32'hB0000000 + 32'(k));
         cyc();
      end
      m_rvalid = 1'b0;
      #1 chk("drain_outstanding", 32'(outstanding), 32'h0);

      // push and pop in the same cycle
      addr[63:32] = 32'h4000;
      av          = 2'b10;
      cyc();
      cyc();
      exp_q.push_back(1'b1);
      addr[31:0] = 32'h5000;
      av         = 2'b01;
      #1 chk("pp_outstanding1", 32'(outstanding), 32'h1);
      cyc();
      m_rvalid = 1'b1;
      m_rdata  = 32'h77;
      #1;
      chk("pp_mem_av", 32'(m_av), 32'h1);
      chk("pp_rx_valid", 32'(rx_valid), onehot(exp_q[0]));
      chk("pp_rx_data", rx_data, 32'h77);
      cyc();
      id = exp_q.pop_front();
      exp_q.push_back(1'b0);
      av       = 2'b00;
      m_rvalid = 1'b0;
      #1 chk("pp_outstanding_same", 32'(outstanding), 32'h1);
      m_rvalid = 1'b1;
      m_rdata  = 32'h88;
      #1;
      id = exp_q.pop_front();
      chk("pp_order_rx_valid", 32'(rx_valid), onehot(id));
      cyc();
      m_rvalid = 1'b0;
      #1 chk("pp_outstanding0", 32'(outstanding), 32'h0);

      // unexpected response with empty FIFO
      m_rvalid = 1'b1;
      m_rdata  = 32'h99;
      #1;
      chk("unexp_mem_rready", 32'(m_rready), 32'h0);
      chk("unexp_rx_valid", 32'(rx_valid), 32'h0);
      cyc();
      m_rvalid = 1'b0;
      #1 chk("unexp_err_set", 32'(err), 32'h1);
      cyc();
      cyc();
      #1 chk("unexp_err_sticky", 32'(err), 32'h1);

      // asynchronous reset with two reads in flight
      addr = {32'h7000, 32'h6000};
      av   = 2'b11;
      cyc();
      cyc();
      cyc();
      cyc();
      #1 chk("mid_outstanding2", 32'(outstanding), 32'h2);
      cyc();
      #1 chk("mid_mem_av", 32'(m_av), 32'h1);
      rst_n    = 1'b0;
      m_rvalid = 1'b1;
      #1;
      chk("mid_rst_mem_av", 32'(m_av), 32'h0);
      chk("mid_rst_send_ready", 32'(send_ready), 32'h0);
      chk("mid_rst_outstanding", 32'(outstanding), 32'h0);
      chk("mid_rst_err", 32'(err), 32'h0);
      chk("mid_rst_rx_valid", 32'(rx_valid), 32'h0);
      chk("mid_rst_mem_rready", 32'(m_rready), 32'h0);
      av       = 2'b00;
      m_rvalid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      #1;
      chk("post_rst_outstanding", 32'(outstanding), 32'h0);
      chk("post_rst_err", 32'(err), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
